// File: rtl/cp0_exc_ctrl.sv
// CP0 block: exception entry/return, maskable interrupt request, prescaled Count/Compare timer.
// Optional BadVAddr register enabled by defining CP0_BADVADDR_EN.
module cp0_exc_ctrl #(
   parameter int          HW_INT_NUM = 6,
   parameter int          COUNT_DIV  = 1,
   parameter logic [31:0] PRID_VAL   = 32'h004C0102
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  we_i,
   input  logic [4:0]            w_addr_i,
   input  logic [31:0]           data_i,
   input  logic [4:0]            r_addr_i,
   output logic [31:0]           data_o,
   input  logic [HW_INT_NUM-1:0] hw_int_i,
   input  logic                  exc_valid_i,
   input  logic [4:0]            exc_code_i,
   input  logic [31:0]           exc_pc_i,
   input  logic                  exc_ds_i,
   input  logic [31:0]           exc_badva_i,
   input  logic                  eret_i,
   output logic [31:0]           status_o,
   output logic [31:0]           cause_o,
   output logic [31:0]           epc_o,
   output logic                  int_req_o,
   output logic                  timer_int_o
);

   localparam int            PW        = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(COUNT_DIV - 1);

   logic [31:0]   count_q, count_d, compare_q, compare_d, epc_q, epc_d;
   logic [PW-1:0] presc_q, presc_d;
   logic [7:0]    im_q, im_d;
   logic          exl_q, exl_d, ie_q, ie_d;
   logic          bd_q, bd_d, iv_q, iv_d, wp_q, wp_d;
   logic [5:0]    ip_hw_q, ip_hw_d;
   logic [1:0]    ip_sw_q, ip_sw_d;
   logic [4:0]    exccode_q, exccode_d;
   logic          timer_q, timer_d, int_req_q, int_req_d;
   logic          tick;
   logic          wr_count, wr_compare, wr_status, wr_cause, wr_epc;
   logic [31:0]   badva_rd;

   assign status_o    = {3'b000, 1'b1, 12'h000, im_q, 6'b000000, exl_q, ie_q};
   assign cause_o     = {bd_q, 7'h00, iv_q, wp_q, 6'h00, ip_hw_q, ip_sw_q, 1'b0, exccode_q, 2'b00};
   assign epc_o       = epc_q;
   assign int_req_o   = int_req_q;
   assign timer_int_o = timer_q;

   assign wr_count   = we_i && (w_addr_i == 5'd9);
   assign wr_compare = we_i && (w_addr_i == 5'd11);
   assign wr_status  = we_i && (w_addr_i == 5'd12);
   assign wr_cause   = we_i && (w_addr_i == 5'd13);
   assign wr_epc     = we_i && (w_addr_i == 5'd14);
   assign tick       = (presc_q == PRESC_MAX);

   always_comb begin
      count_d   = wr_count ? data_i : count_q + {31'd0, tick};
      presc_d   = (wr_count || tick) ? '0 : presc_q + 1'b1;
      compare_d = wr_compare ? data_i : compare_q;
      // Compare write clears the flag even if the match fires in the same cycle.
      timer_d   = wr_compare ? 1'b0
                : (timer_q | ((count_q == compare_q) && (compare_q != 32'd0)));

      ip_hw_d = '0;
      for (int k = 0; k < HW_INT_NUM; k++) ip_hw_d[k] = hw_int_i[k];
      ip_hw_d[5] = ip_hw_d[5] | timer_q;

      im_d  = wr_status ? data_i[15:8] : im_q;
      ie_d  = wr_status ? data_i[0]    : ie_q;
      exl_d = exc_valid_i ? 1'b1 : eret_i ? 1'b0 : wr_status ? data_i[1] : exl_q;

      ip_sw_d   = wr_cause ? data_i[9:8] : ip_sw_q;
      wp_d      = wr_cause ? data_i[22]  : wp_q;
      iv_d      = wr_cause ? data_i[23]  : iv_q;
      exccode_d = exc_valid_i ? exc_code_i : exccode_q;
      bd_d      = (exc_valid_i && !exl_q) ? exc_ds_i : bd_q;

      // A nested exception (EXL already set) keeps the original return address.
      if (exc_valid_i)
         epc_d = exl_q ? epc_q : (exc_ds_i ? exc_pc_i - 32'd4 : exc_pc_i);
      else
         epc_d = wr_epc ? data_i : epc_q;

      int_req_d = (|(cause_o[15:8] & im_q)) & ie_q & ~exl_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q   <= '0;
         presc_q   <= '0;
         compare_q <= '0;
         epc_q     <= '0;
         im_q      <= '0;
         exl_q     <= 1'b0;
         ie_q      <= 1'b0;
         bd_q      <= 1'b0;
         iv_q      <= 1'b0;
         wp_q      <= 1'b0;
         ip_hw_q   <= '0;
         ip_sw_q   <= '0;
         exccode_q <= '0;
         timer_q   <= 1'b0;
         int_req_q <= 1'b0;
      end else begin
         count_q   <= count_d;
         presc_q   <= presc_d;
         compare_q <= compare_d;
         epc_q     <= epc_d;
         im_q      <= im_d;
         exl_q     <= exl_d;
         ie_q      <= ie_d;
         bd_q      <= bd_d;
         iv_q      <= iv_d;
         wp_q      <= wp_d;
         ip_hw_q   <= ip_hw_d;
         ip_sw_q   <= ip_sw_d;
         exccode_q <= exccode_d;
         timer_q   <= timer_d;
         int_req_q <= int_req_d;
      end
   end

`ifdef CP0_BADVADDR_EN
   logic [31:0] badva_q;

   always_ff @(posedge clk) begin
      if (rst)
         badva_q <= '0;
      else if (exc_valid_i && ((exc_code_i == 5'd4) || (exc_code_i == 5'd5)))
         badva_q <= exc_badva_i;
   end

   assign badva_rd = badva_q;
`else
   logic badva_unused;

   assign badva_unused = ^exc_badva_i;
   assign badva_rd     = 32'd0;
`endif

   always_comb begin
      data_o = 32'd0;
      if (!rst) begin
         case (r_addr_i)
            5'd8:    data_o = badva_rd;
            5'd9:    data_o = count_q;
            5'd11:   data_o = compare_q;
            5'd12:   data_o = status_o;
            5'd13:   data_o = cause_o;
            5'd14:   data_o = epc_q;
            5'd15:   data_o = PRID_VAL;
            5'd16:   data_o = 32'h0000_8000;
            default: data_o = 32'd0;
         endcase
      end
   end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Bench for cp0_exc_ctrl: directed scenarios then randomized traffic, all checked
// against a word-level reference model of the CP0 register rules.
module tb_cp0_exc_ctrl;

   localparam int          HW  = 6;
   localparam int          DIV = 4;
   localparam logic [31:0] PRID = 32'h004C0102;

   logic          clk = 1'b0;
   logic          rst;
   logic          we;
   logic [4:0]    w_addr;
   logic [31:0]   wdata;
   logic [4:0]    r_addr;
   logic [31:0]   data_o;
   logic [HW-1:0] hw_int;
   logic          exc_valid;
   logic [4:0]    exc_code;
   logic [31:0]   exc_pc;
   logic          exc_ds;
   logic [31:0]   exc_badva;
   logic          eret;
   logic [31:0]   status_o, cause_o, epc_o;
   logic          int_req_o, timer_int_o;

   int checks   = 0;
   int failures = 0;

   // Reference model state (whole architectural words)
   logic [31:0] m_count, m_compare, m_status, m_cause, m_epc, m_badva;
   logic        m_timer, m_intreq;
   int          m_since;

   cp0_exc_ctrl #(.HW_INT_NUM(HW), .COUNT_DIV(DIV), .PRID_VAL(PRID)) dut (
      .clk(clk), .rst(rst), .we_i(we), .w_addr_i(w_addr), .data_i(wdata),
      .r_addr_i(r_addr), .data_o(data_o), .hw_int_i(hw_int),
      .exc_valid_i(exc_valid), .exc_code_i(exc_code), .exc_pc_i(exc_pc),
      .exc_ds_i(exc_ds), .exc_badva_i(exc_badva), .eret_i(eret),
      .status_o(status_o), .cause_o(cause_o), .epc_o(epc_o),
      .int_req_o(int_req_o), .timer_int_o(timer_int_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] m_read(input logic [4:0] a);
      if (rst) return 32'd0;
      case (a)
`ifdef CP0_BADVADDR_EN
         5'd8:  return m_badva;
`endif
         5'd9:  return m_count;
         5'd11: return m_compare;
         5'd12: return m_status;
         5'd13: return m_cause;
         5'd14: return m_epc;
         5'd15: return PRID;
         5'd16: return 32'h0000_8000;
         default: return 32'd0;
      endcase
   endfunction

   task automatic check_all();
      chk("data_o", data_o, m_read(r_addr));
      chk("status", status_o, m_status);
      chk("cause", cause_o, m_cause);
      chk("epc", epc_o, m_epc);
      chk("int_req", {31'd0, int_req_o}, {31'd0, m_intreq});
      chk("timer_int", {31'd0, timer_int_o}, {31'd0, m_timer});
   endtask

   // One clock: model next state from the applied inputs, edge, compare, clear strobes.
   task automatic cyc();
      logic [31:0] n_count, n_compare, n_status, n_cause, n_epc, n_badva;
      logic        n_timer, n_intreq, wr;
      int          n_since;
      n_count = m_count; n_compare = m_compare; n_status = m_status;
      n_cause = m_cause; n_epc = m_epc; n_badva = m_badva;
      n_timer = m_timer; n_since = m_since;
      if (rst) begin
         n_count = 0; n_compare = 0; n_status = 32'h1000_0000; n_cause = 0;
         n_epc = 0; n_badva = 0; n_timer = 0; n_intreq = 0; n_since = 0;
      end else begin
         if ((m_since % DIV) == DIV - 1) n_count = m_count + 1;
         n_since = m_since + 1;
         if (we && w_addr == 9) begin n_count = wdata; n_since = 0; end
         if (m_count == m_compare && m_compare != 0) n_timer = 1'b1;
         if (we && w_addr == 11) begin n_compare = wdata; n_timer = 1'b0; end
         n_intreq = ((m_cause[15:8] & m_status[15:8]) != 0) && m_status[0] && !m_status[1];
         if (we && w_addr == 12) n_status = (m_status & ~32'h0000_FF03) | (wdata & 32'h0000_FF03);
         if (we && w_addr == 13) n_cause = (m_cause & ~32'h00C0_0300) | (wdata & 32'h00C0_0300);
         n_cause[15:10] = {hw_int[5] | m_timer, hw_int[4:0]};
         wr = we && w_addr == 14 && !exc_valid;
         if (wr) n_epc = wdata;
         if (eret) n_status[1] = 1'b0;
         if (exc_valid) begin
            n_status[1]  = 1'b1;
            n_cause[6:2] = exc_code;
            if (!m_status[1]) begin
               n_epc       = exc_ds ? exc_pc - 4 : exc_pc;
               n_cause[31] = exc_ds;
            end
            if (exc_code == 4 || exc_code == 5) n_badva = exc_badva;
         end
      end
      @(posedge clk);
      m_count = n_count; m_compare = n_compare; m_status = n_status; m_cause = n_cause;
      m_epc = n_epc; m_badva = n_badva; m_timer = n_timer; m_intreq = n_intreq;
      m_since = n_since;
      #1;
      check_all();
      we = 0; exc_valid = 0; eret = 0;
   endtask

   task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
      we = 1; w_addr = a; wdata = d;
      cyc();
   endtask

   task automatic take_exc(input logic [4:0] code, input logic [31:0] pc, input logic ds,
                           input logic [31:0] badva);
      exc_valid = 1; exc_code = code; exc_pc = pc; exc_ds = ds; exc_badva = badva;
      cyc();
   endtask

   initial begin
      int  n;
      bit  found;
      int  addrs[10] = '{8, 9, 11, 12, 13, 14, 15, 16, 3, 9};
      rst = 1; we = 0; w_addr = 0; wdata = 0; r_addr = 5'd15; hw_int = 0;
      exc_valid = 0; exc_code = 0; exc_pc = 0; exc_ds = 0; exc_badva = 0; eret = 0;
      m_since = 0;
      cyc();
      cyc();
      chk("rst_data_o", data_o, 32'd0);
      rst = 0;
      r_addr = 5'd16;
      cyc();
      chk("reset_status", status_o, 32'h1000_0000);
      chk("reset_config", data_o, 32'h0000_8000);

      // Timer with prescaler 4, Compare=3
      mtc0(5'd9, 32'd0);
      r_addr = 5'd9;
      mtc0(5'd11, 32'd3);
      found = 0; n = 0;
      while (!found && n < 20) begin
         cyc();
         n++;
         found = timer_int_o;
      end
      chk("timer_latency", {31'd0, (found && n >= 12 && n <= 13)}, 32'd1);
      cyc();
      chk("timer_ip7", {31'd0, cause_o[15]}, 32'd1);
      mtc0(5'd11, 32'd0);
      chk("timer_clear", {31'd0, timer_int_o}, 32'd0);

      // Hardware interrupt through to int_req
      hw_int = 6'b000001;
      mtc0(5'd12, 32'h1000_0401);
      chk("ip2_set", {31'd0, cause_o[10]}, 32'd1);
      cyc();
      chk("int_req_set", {31'd0, int_req_o}, 32'd1);
      mtc0(5'd12, 32'h1000_0403);
      cyc();
      chk("int_req_exl", {31'd0, int_req_o}, 32'd0);
      hw_int = 0;
      mtc0(5'd12, 32'h1000_0000);

      // Exception in delay slot, then nested exception
      r_addr = 5'd14;
      take_exc(5'h08, 32'hBFC0_0100, 1'b1, 32'd0);
      chk("exc_epc", epc_o, 32'hBFC0_00FC);
      chk("exc_cause", cause_o & 32'h8000_007C, 32'h8000_0020);
      chk("exc_exl", {31'd0, status_o[1]}, 32'd1);
      take_exc(5'h0A, 32'h0000_1000, 1'b0, 32'd0);
      chk("nested_epc", epc_o, 32'hBFC0_00FC);

      // Exception beats MTC0 EPC; ERET clears EXL
      eret = 1;
      cyc();
      we = 1; w_addr = 5'd14; wdata = 32'h0000_1234;
      take_exc(5'h0C, 32'h8000_0200, 1'b0, 32'd0);
      chk("exc_vs_mtc0_epc", epc_o, 32'h8000_0200);
      eret = 1;
      cyc();
      chk("eret_exl", {31'd0, status_o[1]}, 32'd0);

      // Cause write mask, read-only PRId
      mtc0(5'd13, 32'hFFFF_FFFF);
      chk("cause_mask", cause_o & 32'h00C0_0300, 32'h00C0_0300);
      r_addr = 5'd15;
      mtc0(5'd15, 32'h0);
      chk("prid_ro", data_o, PRID);
      mtc0(5'd13, 32'h0);

      // BadVAddr
      r_addr = 5'd8;
      take_exc(5'd4, 32'h0000_2000, 1'b0, 32'h0000_0003);
`ifdef CP0_BADVADDR_EN
      chk("badvaddr", data_o, 32'h0000_0003);
`else
      chk("badvaddr", data_o, 32'd0);
`endif
      eret = 1;
      cyc();

      // Randomized traffic
      for (int i = 0; i < 600; i++) begin
         r_addr = 5'($urandom_range(0, 31));
         if ($urandom_range(0, 3) == 0) hw_int = HW'($urandom);
         if ($urandom_range(0, 2) == 0) begin
            we = 1;
            w_addr = 5'(addrs[$urandom_range(0, 9)]);
            wdata = $urandom_range(0, 1) ? 32'($urandom_range(0, 30)) : $urandom;
         end
         if ($urandom_range(0, 11) == 0) begin
            exc_valid = 1;
            exc_code = 5'($urandom_range(0, 7));
            exc_pc = $urandom & ~32'h3;
            exc_ds = 1'($urandom);
            exc_badva = $urandom;
         end
         if ($urandom_range(0, 11) == 0) eret = 1;
         rst = ($urandom_range(0, 149) == 0);
         cyc();
         rst = 0;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
